// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types, defaults and hazard helper for the stall controller
package hazard_stall_ctrl_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Pipeline registers load these values when a stage is turned into a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic loadUse(input logic memRead, input logic [4:0] exRt,
                                   input logic [4:0] idRs, input logic [4:0] idRt);
    return memRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - enable-driven counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush/freeze sequencing and dmem handshake for the 5-stage pipe
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RsAddr_i,
  input  logic [4:0]       IF_ID_RtAddr_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RtAddr_i,
  input  logic             Branch_i,
  input  logic             Equal_i,
  input  logic             EX_MEM_MemRead_i,
  input  logic             EX_MEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic             MEM_WB_Bubble_o,
  output logic             dmem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mw_cnt_o,
  output logic [CNT_W-1:0] fl_cnt_o
);

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] nextCnt;
  logic             released;
  logic             memErr;

  logic memop;
  logic lu;
  logic taken;
  logic freeze;
  logic luStall;
  logic flush;

  assign memop = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
  assign lu    = loadUse(ID_EX_MemRead_i, ID_EX_RtAddr_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i);
  assign taken = Branch_i & Equal_i;

  // After a timeout the stuck access is abandoned: one cycle with no freeze lets it drain.
  assign freeze  = rst_i & memop & ~dmem_ack_i & ~released;
  assign luStall = rst_i & lu & ~freeze;
  assign flush   = rst_i & taken & ~freeze & ~lu;

  assign nextCnt = (state == WAIT) ? waitCnt + CNT_W'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= RUN;
      waitCnt  <= '0;
      released <= 1'b0;
      memErr   <= 1'b0;
    end else begin
      released <= 1'b0;
      if (freeze) begin
        if (nextCnt == CNT_W'(TIMEOUT - 1)) begin
          state    <= RUN;
          waitCnt  <= '0;
          memErr   <= 1'b1;
          released <= 1'b1;
        end else begin
          state   <= WAIT;
          waitCnt <= nextCnt;
        end
      end else begin
        state <= RUN;
      end
    end
  end

  assign PC_Write_o      = ~freeze & ~luStall;
  assign IF_ID_Write_o   = ~freeze & ~luStall;
  assign IF_ID_Flush_o   = flush;
  assign ID_EX_Bubble_o  = luStall;
  assign Pipe_Freeze_o   = freeze;
  assign MEM_WB_Bubble_o = freeze;
  assign dmem_req_o      = rst_i & ((state == WAIT) | memop);
  assign mem_err_o       = memErr;

  sat_counter #(.W(CNT_W)) luCounter (
    .clk   (clk_i),
    .rstN  (rst_i),
    .en    (luStall),
    .count (lu_cnt_o)
  );

  sat_counter #(.W(CNT_W)) mwCounter (
    .clk   (clk_i),
    .rstN  (rst_i),
    .en    (freeze),
    .count (mw_cnt_o)
  );

  sat_counter #(.W(CNT_W)) flCounter (
    .clk   (clk_i),
    .rstN  (rst_i),
    .en    (flush),
    .count (fl_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  // {PC_Write, IF_ID_Write, Flush, ID_EX_Bubble, Freeze, MEM_WB_Bubble, req, err}
  localparam logic [7:0] NORM  = 8'b1100_0000;
  localparam logic [7:0] STALL = 8'b0001_0000;
  localparam logic [7:0] FLUSH = 8'b1110_0000;
  localparam logic [7:0] FRZ   = 8'b0000_1110;
  localparam logic [7:0] REQ   = 8'b1100_0010;
  localparam logic [7:0] ERR   = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [4:0]    rsAddr, rtAddr, exRtAddr;
  logic          exMemRead, branch, equal, memRd, memWr, ack;
  logic          pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze, memWbBubble, dmemReq, memErr;
  logic [CW-1:0] luCnt, mwCnt, flCnt;

  typedef struct {
    string      tag;
    logic [7:0] outs;
    int         lu;
    int         mw;
    int         fl;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  int         expLu = 0;
  int         expMw = 0;
  int         expFl = 0;
  logic [7:0] loopExp;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .IF_ID_RsAddr_i    (rsAddr),
    .IF_ID_RtAddr_i    (rtAddr),
    .ID_EX_MemRead_i   (exMemRead),
    .ID_EX_RtAddr_i    (exRtAddr),
    .Branch_i          (branch),
    .Equal_i           (equal),
    .EX_MEM_MemRead_i  (memRd),
    .EX_MEM_MemWrite_i (memWr),
    .dmem_ack_i        (ack),
    .PC_Write_o        (pcWrite),
    .IF_ID_Write_o     (ifIdWrite),
    .IF_ID_Flush_o     (ifIdFlush),
    .ID_EX_Bubble_o    (idExBubble),
    .Pipe_Freeze_o     (pipeFreeze),
    .MEM_WB_Bubble_o   (memWbBubble),
    .dmem_req_o        (dmemReq),
    .mem_err_o         (memErr),
    .lu_cnt_o          (luCnt),
    .mw_cnt_o          (mwCnt),
    .fl_cnt_o          (flCnt)
  );

  function automatic int satInc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic lRd, input logic [4:0] exRt, input logic br, input logic eq,
                      input logic mr, input logic mw, input logic a, input logic [7:0] outs);
    exp_t e;
    rst_i = r; rsAddr = rs; rtAddr = rt; exMemRead = lRd; exRtAddr = exRt;
    branch = br; equal = eq; memRd = mr; memWr = mw; ack = a;
    if (!r) begin
      expLu = 0; expMw = 0; expFl = 0;
    end
    e.tag = tag; e.outs = outs; e.lu = expLu; e.mw = expMw; e.fl = expFl;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      cur = sb.pop_front();
      check({cur.tag, "_outs"},
            {24'd0, pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze, memWbBubble, dmemReq, memErr},
            {24'd0, cur.outs});
      check({cur.tag, "_lu_cnt"}, 32'(luCnt), 32'(cur.lu));
      check({cur.tag, "_mw_cnt"}, 32'(mwCnt), 32'(cur.mw));
      check({cur.tag, "_fl_cnt"}, 32'(flCnt), 32'(cur.fl));
    end
    if (r) begin
      if (outs[4]) expLu = satInc(expLu);
      if (outs[3]) expMw = satInc(expMw);
      if (outs[5]) expFl = satInc(expFl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //    tag            r  rs rt lRd exRt br eq mr mw ack expected
    step("reset",        0, 5, 0, 1,  5,   1, 1, 1, 0, 0, NORM);
    step("idle",         1, 0, 0, 0,  0,   0, 0, 0, 0, 0, NORM);
    step("lu_rs",        1, 5, 0, 1,  5,   0, 0, 0, 0, 0, STALL);
    step("lu_clear",     1, 5, 0, 0,  5,   0, 0, 0, 0, 0, NORM);
    step("lu_r0",        1, 0, 0, 1,  0,   0, 0, 0, 0, 0, NORM);
    step("lu_rt",        1, 1, 7, 1,  7,   0, 0, 0, 0, 0, STALL);
    step("br_taken",     1, 0, 0, 0,  0,   1, 1, 0, 0, 0, FLUSH);
    step("br_lu",        1, 5, 0, 1,  5,   1, 1, 0, 0, 0, STALL);
    step("br_ne",        1, 0, 0, 0,  0,   1, 0, 0, 0, 0, NORM);
    step("ld_w0",        1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("ld_w1",        1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("ld_w2",        1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("ld_ack",       1, 0, 0, 0,  0,   0, 0, 1, 0, 1, REQ);
    step("st_b2b",       1, 0, 0, 0,  0,   0, 0, 0, 1, 0, FRZ);
    step("st_ack",       1, 0, 0, 0,  0,   0, 0, 0, 1, 1, REQ);
    step("zero_wait",    1, 0, 0, 0,  0,   0, 0, 1, 0, 1, REQ);
    step("zw_after",     1, 0, 0, 0,  0,   0, 0, 0, 0, 0, NORM);
    step("spur_ack",     1, 0, 0, 0,  0,   0, 0, 0, 0, 1, NORM);
    step("frz_sup",      1, 5, 0, 1,  5,   1, 1, 1, 0, 0, FRZ);
    step("frz_sup_ack",  1, 5, 0, 1,  5,   1, 1, 1, 0, 1, STALL | 8'b0000_0010);
    step("to_0",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("to_1",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("to_2",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("to_3",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ);
    step("to_release",   1, 0, 0, 0,  0,   0, 0, 1, 0, 0, REQ | ERR);
    step("to_idle",      1, 0, 0, 0,  0,   0, 0, 0, 0, 0, NORM | ERR);
    step("to_new",       1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ | ERR);
    step("to_new_ack",   1, 0, 0, 0,  0,   0, 0, 1, 0, 1, REQ | ERR);
    step("rw_0",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ | ERR);
    step("rw_1",         1, 0, 0, 0,  0,   0, 0, 1, 0, 0, FRZ | ERR);
    step("rst_in_wait",  0, 0, 0, 0,  0,   0, 0, 1, 0, 0, NORM);
    for (int i = 0; i < 20; i++) begin
      loopExp = (i % 5 == 4) ? (REQ | ERR) : (FRZ | ((i > 4) ? ERR : 8'h00));
      step("sat",        1, 0, 0, 0,  0,   0, 0, 1, 0, 0, loopExp);
    end
    step("sat_hold",     1, 0, 0, 0,  0,   0, 0, 0, 0, 0, NORM | ERR);
    check("mw_saturated", 32'(mwCnt), 32'd15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage CPU. It sits beside the forwarding unit and owns every stall, bubble, freeze and flush decision.
- It detects load-use hazards that forwarding cannot cover and branch-taken flushes in ID.
- It runs the request/acknowledge handshake with a multi-cycle data memory and freezes the pipeline while a memory access is outstanding.
- It keeps saturating stall-statistics counters and a memory-timeout error flag.

Parameters:
- CNT_W, 16, width of each statistics counter.
- TIMEOUT, 64, maximum cycles spent waiting for dmem_ack_i before flagging an error (1 to 2^CNT_W-1).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- IF_ID_RsAddr_i  input  5  Rs of the instruction in ID
- IF_ID_RtAddr_i  input  5  Rt of the instruction in ID
- ID_EX_MemRead_i  input  1  instruction in EX is a load
- ID_EX_RtAddr_i  input  5  load destination in EX
- Branch_i  input  1  instruction in ID is a branch
- Equal_i  input  1  ID register comparison is equal
- EX_MEM_MemRead_i  input  1  MEM-stage instruction reads dmem
- EX_MEM_MemWrite_i  input  1  MEM-stage instruction writes dmem
- dmem_ack_i  input  1  data memory completes the current access
- PC_Write_o  output  1  PC update enable
- IF_ID_Write_o  output  1  IF/ID register enable
- IF_ID_Flush_o  output  1  IF/ID replaced by NOP
- ID_EX_Bubble_o  output  1  control fields of ID/EX zeroed
- Pipe_Freeze_o  output  1  hold ID/EX and EX/MEM
- MEM_WB_Bubble_o  output  1  MEM/WB receives a NOP
- dmem_req_o  output  1  memory request
- mem_err_o  output  1  sticky timeout error
- lu_cnt_o  output  CNT_W  load-use stall cycles
- mw_cnt_o  output  CNT_W  memory-wait cycles
- fl_cnt_o  output  CNT_W  flushes

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to RUN.
  - Wait counter, all statistics counters and mem_err_o clear to 0.
  - While in reset, outputs are: PC_Write_o=1, IF_ID_Write_o=1, dmem_req_o=0, and all bubble, flush and freeze outputs 0.
- memop = EX_MEM_MemRead_i | EX_MEM_MemWrite_i.
- FSM states and transitions:
  - RUN:
    - dmem_req_o = memop.
    - If memop and !dmem_ack_i, go to WAIT and clear the wait counter.
    - If memop and dmem_ack_i in the same cycle, the access completes with zero wait and there is no freeze.
  - WAIT:
    - dmem_req_o=1, held constant until ack.
    - Wait counter increments every cycle.
    - On dmem_ack_i, go to RUN; the pipeline advances on that same edge.
    - If the wait counter reaches TIMEOUT-1 without an ack, set mem_err_o and go to RUN (access abandoned, pipeline released).
  - dmem_ack_i while dmem_req_o=0 is ignored.
- freeze = memop & !dmem_ack_i, in either state. Unless mem_err_o has just released the pipeline, this is the same as dmem_req_o & !dmem_ack_i.
  - While freeze=1: PC_Write_o=0, IF_ID_Write_o=0, Pipe_Freeze_o=1, MEM_WB_Bubble_o=1.
  - While freeze=1, load-use and flush outputs are suppressed to 0.
- Load-use hazard: lu = ID_EX_MemRead_i & (ID_EX_RtAddr_i!=0) & (ID_EX_RtAddr_i==IF_ID_RsAddr_i | ID_EX_RtAddr_i==IF_ID_RtAddr_i).
  - When lu & !freeze: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1.
  - This lasts exactly one cycle; the bubble clears the condition.
- Branch flush: taken = Branch_i & Equal_i.
  - IF_ID_Flush_o = taken & !freeze & !lu.
  - A branch that depends on a load stalls first and is re-evaluated the next cycle.
  - PC_Write_o stays 1 during a flush.
- Priority: freeze > load-use > flush.
- All hazard outputs are combinational from the current inputs and state, with zero-cycle latency.
- Statistics counters increment on a clock edge when their condition holds, and saturate at all-ones (no wrap):
  - lu_cnt_o: lu & !freeze.
  - mw_cnt_o: freeze.
  - fl_cnt_o: IF_ID_Flush_o.
- mem_err_o clears only on reset.
- Reset asserted mid-WAIT drops dmem_req_o immediately, since reset is asynchronous.
- A new memop arriving in the cycle after an ack is a fresh request; back-to-back accesses need no idle cycle.

Decomposition:
- Shared package holds:
  - FSM state constants RUN=1'b0, WAIT=1'b1.
  - The NOP/bubble encoding used by the pipeline registers.
  - Default CNT_W and TIMEOUT.
- One sub-module: sat_counter (CNT_W-wide, enable, asynchronous active-low clear, saturating), instantiated three times.

Test Plan:
- Load-use: ID_EX_MemRead_i=1, ID_EX_RtAddr_i=5, IF_ID_RsAddr_i=5 -> one cycle of PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1; lu_cnt_o=1. Repeat with ID_EX_RtAddr_i=0 -> no stall.
- Branch taken (Branch_i=1, Equal_i=1, no hazard) -> IF_ID_Flush_o=1, PC_Write_o=1, fl_cnt_o=1. Same stimulus plus a load-use hazard -> flush=0 and stall asserted.
- Load with ack delayed 3 cycles -> dmem_req_o high for 4 cycles, Pipe_Freeze_o and MEM_WB_Bubble_o high for 3, mw_cnt_o=3. Back-to-back store afterwards -> new request in the very next cycle.
- Zero-wait access (dmem_ack_i=1 in the same cycle as memop) -> no freeze, state stays RUN. Spurious ack with no memop -> no effect.
- TIMEOUT=4 and ack never comes -> mem_err_o=1 after 4 cycles, freeze released, FSM in RUN. Reset clears mem_err_o.
- Assert rst_i=0 mid-WAIT -> dmem_req_o=0 immediately and counters 0. Force mw_cnt_o to saturation with CNT_W=4 -> counter holds at 15.
